// File: rtl/front_spi_arb.sv
// Two-requester arbiter/sequencer for the shared front-panel SPI master (LCD = requester 0, switch = requester 1).
// Define SPI_ARB_SW_PRIO_EN to give the switch fixed priority on ties instead of round-robin.
module front_spi_arb #(
    parameter int TIMEOUT    = 8000,
    parameter int GAP_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req,
    input  logic [23:0] i_req0_data,
    input  logic [23:0] i_req1_data,
    input  logic        i_req0_cs,
    input  logic        i_req1_cs,
    output logic [1:0]  o_ack,
    output logic        o_err,
    output logic [23:0] o_rx_data,
    output logic        o_busy,
    output logic        o_spi_start,
    output logic [23:0] o_mosi_data,
    input  logic [23:0] i_miso_data,
    input  logic        i_spi_done,
    output logic        o_lcd_sw_cs
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t      state;
    state_t      state_next;
    logic        winner;
    logic        owner;
    logic        err_flag;
    logic [15:0] to_cnt;
    logic [7:0]  gap_cnt;

`ifdef SPI_ARB_SW_PRIO_EN
    assign winner = i_req[1];
`else
    logic last_owner;

    // On a tie the requester that did not own the bus last time wins.
    assign winner = (i_req == 2'b11) ? ~last_owner : i_req[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_owner <= 1'b1;
        end else if (state == S_IDLE && i_req != 2'b00) begin
            last_owner <= winner;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (i_req != 2'b00) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (i_spi_done || to_cnt == TO_LAST) state_next = S_DONE;
            S_DONE:   state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:    if (gap_cnt == 8'd0) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_spi_start = (state == S_LAUNCH);
        o_ack       = 2'b00;
        o_err       = 1'b0;
        if (state == S_DONE) begin
            o_ack = owner ? 2'b10 : 2'b01;
            o_err = err_flag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            owner       <= 1'b0;
            err_flag    <= 1'b0;
            to_cnt      <= 16'd0;
            gap_cnt     <= 8'd0;
            o_rx_data   <= 24'd0;
            o_mosi_data <= 24'd0;
            o_lcd_sw_cs <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_busy <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    // MOSI word and chip-select change only here, at a grant.
                    if (i_req != 2'b00) begin
                        owner       <= winner;
                        o_mosi_data <= winner ? i_req1_data : i_req0_data;
                        o_lcd_sw_cs <= winner ? i_req1_cs : i_req0_cs;
                    end
                end
                S_LAUNCH: to_cnt <= 16'd0;
                S_WAIT: begin
                    // A done arriving in the timeout cycle still counts as success.
                    if (i_spi_done) begin
                        o_rx_data <= i_miso_data;
                    end else if (to_cnt == TO_LAST) begin
                        err_flag  <= 1'b1;
                        o_rx_data <= 24'd0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    err_flag <= 1'b0;
                    gap_cnt  <= GAP_LOAD;
                end
                S_GAP: if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
                default: ;
            endcase
        end
    end

endmodule
